// File: rtl/norm_param_loader.sv
`default_nettype none
// ============================================================================
//  Module   : norm_param_loader
//  Purpose  : Loads a configured number of parameter words from a
//             valid/ready stream into the normalisation parameter RAM.
//             Words go to consecutive addresses starting at 0, and a
//             one-cycle done pulse follows the last write.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             start, param_num      - load request and word count (IDLE only)
//             s_data/s_valid/s_ready- parameter word stream
//             ram_write_*           - RAM write port (one cycle after handshake)
//             ram_input_data        - RAM write data
//             busy, done            - status (busy when not IDLE, done pulse)
//             checksum              - XOR of all words of the current/last load
//  Config   : NORM_LOADER_CHECKSUM_EN - build the checksum accumulator;
//             when undefined the checksum output is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module norm_param_loader #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   param_num,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [ADDR_BITS-1:0] ram_write_address,
  output logic [WIDTH-1:0]     ram_input_data,
  output logic                 ram_write_enable,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_BITS:0] c_cap = (ADDR_BITS+1)'(1) << ADDR_BITS;
  localparam logic [ADDR_BITS:0] c_one = (ADDR_BITS+1)'(1);

  state_t                 state_q, state_d;
  logic [ADDR_BITS:0]     n_q, n_d;
  logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]       data_q, data_d;

  logic                   w_start_acc;
  logic                   w_hs;
  logic                   w_last;
  logic [ADDR_BITS:0]     w_n_clamped;

  assign w_start_acc = (state_q == S_IDLE) && start;
  assign w_hs        = (state_q == S_LOAD) && s_valid;
  // n_q is at least 1 whenever LOAD is active, so n_q-1 never underflows here.
  assign w_last      = ({1'b0, cnt_q} == (n_q - c_one));
  assign w_n_clamped = (param_num > c_cap) ? c_cap : param_num;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = w_n_clamped;
          cnt_d   = '0;
          state_d = (w_n_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          data_d = s_data;
          // Wraps to 0 only on the final word of a full-capacity load,
          // at which point the FSM leaves LOAD anyway.
          cnt_d  = cnt_q + 1'b1;
          if (w_last) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign s_ready           = (state_q == S_LOAD);
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign ram_write_enable  = we_q;
  assign ram_write_address = addr_q;
  assign ram_input_data    = data_q;

`ifdef NORM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  // Updated on the handshake edge so it lands together with the RAM write.
  always_comb begin
    csum_d = csum_q;
    if (w_start_acc) begin
      csum_d = '0;
    end else if (w_hs) begin
      csum_d = csum_q ^ s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  logic w_unused_start_acc;
  assign w_unused_start_acc = w_start_acc;
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_norm_param_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_norm_param_loader
//  Purpose  : Directed self-checking bench for norm_param_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_norm_param_loader;

  localparam int WIDTH     = 64;
  localparam int ADDR_BITS = 10;
  localparam int CAP       = 1024;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [ADDR_BITS:0]   param_num;
  logic [WIDTH-1:0]     s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [ADDR_BITS-1:0] ram_write_address;
  logic [WIDTH-1:0]     ram_input_data;
  logic                 ram_write_enable;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     checksum;

  always #5 clk = ~clk;

  norm_param_loader #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .param_num         (param_num),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .ram_write_address (ram_write_address),
    .ram_input_data    (ram_input_data),
    .ram_write_enable  (ram_write_enable),
    .busy              (busy),
    .done              (done),
    .checksum          (checksum)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter and write/ready/done monitor, sampled on the falling edge.
  int              cyc = 0;
  int              wr_tot = 0;
  int              done_tot = 0;
  int              rdy_tot = 0;
  logic [9:0]      wr_addr [0:4095];
  logic [63:0]     wr_data [0:4095];
  int              wr_cyc  [0:4095];
  logic [63:0]     mem     [0:CAP-1];
  int              hs_cyc  [0:CAP-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_write_enable === 1'b1) begin
      wr_addr[wr_tot % 4096] <= ram_write_address;
      wr_data[wr_tot % 4096] <= ram_input_data;
      wr_cyc[wr_tot % 4096]  <= cyc;
      mem[ram_write_address] <= ram_input_data;
      wr_tot <= wr_tot + 1;
    end
    if (done === 1'b1)    done_tot <= done_tot + 1;
    if (s_ready === 1'b1) rdy_tot  <= rdy_tot + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word(input logic [63:0] base, input int i);
    return base * 64'(i + 1);
  endfunction

  function automatic logic vpat(input int mode, input int p);
    logic [5:0] pat;
    pat = 6'b101001; // bit0 first: 1,0,0,1,0,1
    if (mode == 0) return 1'b1;
    return pat[p % 6];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".s_ready"}, 64'(s_ready), 64'd0);
    check({tag, ".we"},      64'(ram_write_enable), 64'd0);
    check({tag, ".addr"},    64'(ram_write_address), 64'd0);
    check({tag, ".data"},    ram_input_data, 64'd0);
    check({tag, ".busy"},    64'(busy), 64'd0);
    check({tag, ".done"},    64'(done), 64'd0);
    check({tag, ".csum"},    checksum, 64'd0);
  endtask

  // Starts a load in the current cycle (must be IDLE), streams words with the
  // given valid pattern, checks every write and the completion timing, and
  // returns in the first IDLE cycle after done.
  task automatic run_load(input string tag, input int pnum, input logic [63:0] base,
                          input int mode, input bit offer_extra);
    int          n, s_c, idx, p, k, wb, db, rb, exp_done, exp_rdy;
    logic        rdy;
    logic [63:0] cs;
    n   = (pnum > CAP) ? CAP : pnum;
    wb  = wr_tot; db = done_tot; rb = rdy_tot;
    cs  = '0;
    start = 1'b1; param_num = (ADDR_BITS+1)'(pnum); s_valid = 1'b0;
    s_c = cyc;
    tick();
    start = 1'b0;
    check({tag, ".busy_s1"}, 64'(busy), 64'd1);
    idx = 0; p = 0;
    while (idx < n && p < 5000) begin
      s_valid = vpat(mode, p);
      s_data  = word(base, idx);
      rdy     = s_ready;
      tick();
      if (s_valid && rdy) begin
        hs_cyc[idx] = cyc - 1;
        cs = cs ^ word(base, idx);
        idx++;
      end
      p++;
    end
    check({tag, ".accepted"}, 64'(idx), 64'(n));
    s_valid = offer_extra;
    s_data  = word(base, idx);
    k = 0;
    while (done !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check({tag, ".done_seen"}, 64'(done), 64'd1);
    exp_done = (n == 0) ? s_c + 1 : hs_cyc[n-1] + 2;
    check({tag, ".done_cyc"}, 64'(cyc), 64'(exp_done));
    tick();
    check({tag, ".busy_end"}, 64'(busy), 64'd0);
    check({tag, ".rdy_end"},  64'(s_ready), 64'd0);
    check({tag, ".done_end"}, 64'(done), 64'd0);
    s_valid = 1'b0;
    check({tag, ".n_writes"}, 64'(wr_tot - wb), 64'(n));
    check({tag, ".n_done"},   64'(done_tot - db), 64'd1);
    exp_rdy = (n == 0) ? 0 : hs_cyc[n-1] - s_c;
    check({tag, ".rdy_cycles"}, 64'(rdy_tot - rb), 64'(exp_rdy));
    for (int i = 0; i < n && i < (wr_tot - wb); i++) begin
      check({tag, ".wr_addr"}, 64'(wr_addr[(wb + i) % 4096]), 64'(i));
      check({tag, ".wr_data"}, wr_data[(wb + i) % 4096], word(base, i));
      check({tag, ".wr_cyc"},  64'(wr_cyc[(wb + i) % 4096]), 64'(hs_cyc[i] + 1));
    end
`ifdef NORM_LOADER_CHECKSUM_EN
    check({tag, ".checksum"}, checksum, cs);
`else
    check({tag, ".checksum"}, checksum, 64'd0);
`endif
  endtask

  initial begin : main
    int          wb, s_c;
    logic [63:0] d0, d1;
    rst = 1'b1; start = 1'b0; param_num = '0; s_data = '0; s_valid = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("idle");

    // Four words, continuous valid.
    run_load("n4", 4, 64'h11, 0, 1'b0);
`ifdef NORM_LOADER_CHECKSUM_EN
    check("n4.csum44", checksum, 64'h44);
`endif
    // Back-to-back start in the first IDLE cycle, with valid gaps.
    run_load("n3gap", 3, 64'hA5A5_0000_0000_0001, 1, 1'b0);
    // Zero-length load.
    run_load("n0", 0, 64'h77, 0, 1'b0);
    // Over-capacity request clamps; an extra word stays on offer.
    run_load("clamp", CAP + 1, 64'h1_0000_0003, 0, 1'b1);

    // Ignored start during LOAD, then reset after two words.
    tick();
    d0 = 64'hDEAD_BEEF_0000_0001;
    d1 = 64'hDEAD_BEEF_0000_0002;
    wb = wr_tot;
    start = 1'b1; param_num = 11'd5;
    s_c = cyc;
    tick();
    start = 1'b1; param_num = 11'd7; s_valid = 1'b1; s_data = d0;
    tick();
    start = 1'b0; s_data = d1;
    tick();
    s_valid = 1'b0; rst = 1'b1;
    tick();
    check_idle("rst_mid");
    rst = 1'b0;
    check("rst_mid.cyc", 64'(cyc), 64'(s_c + 4));
    check("rst_mid.n_writes", 64'(wr_tot - wb), 64'd2);
    check("rst_mid.mem0", mem[0], d0);
    check("rst_mid.mem1", mem[1], d1);
    tick();
    run_load("fresh", 3, 64'h5A, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/norm_param_loader.md
# norm_param_loader

Stream-to-RAM loader that fills the per-channel normalisation parameter RAM (the distributed RAM read by the Conv Norm stage) before a layer starts. It accepts a configured number of parameter words from the DMA-side valid/ready stream and writes them to consecutive RAM addresses starting at 0. When the last word has been written it pulses `done`, so the layer controller can release the convolution pipeline.

## Interface
Parameters:
- `WIDTH`, 64: parameter word width; equals the RAM data width.
- `ADDR_BITS`, 10: RAM address width; capacity is 2**ADDR_BITS words.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  load request; sampled only in IDLE.
- `param_num`  in  ADDR_BITS+1  number of words to load; sampled on accepted `start`.
- `s_data`  in  WIDTH  parameter word from stream.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts a word this cycle.
- `ram_write_address`  out  ADDR_BITS  to RAM write port.
- `ram_input_data`  out  WIDTH  to RAM write port.
- `ram_write_enable`  out  1  to RAM write port.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `checksum`  out  WIDTH  XOR of all words accepted in the current/last load.

## Operation
- States: IDLE, LOAD, WAIT, DONE.
- IDLE: `s_ready`=0. On `start`=1, latch `n = min(param_num, 2**ADDR_BITS)`, clear word counter and `checksum`. If `n`=0 go to DONE, otherwise go to LOAD.
- LOAD: `s_ready`=1. A handshake is `s_valid && s_ready`. For each handshake, register the word and the counter value. The registered counter value becomes the RAM address and the counter then increments. On the handshake where counter = `n`-1, go to WAIT.
- WAIT: `s_ready`=0. The last write is presented this cycle. Next state is DONE.
- DONE: `done`=1 for this single cycle. Next state is IDLE.
- Addresses run 0..`n`-1 with no wrap. The word at address `n`-1 is the last one written; RAM contents above it are untouched.
- `start` outside IDLE is ignored. `param_num` changes outside the `start` cycle have no effect.
- Back-to-back loads: `start` may be asserted in the cycle after DONE (first IDLE cycle).
- `s_valid` gaps in LOAD stall the loader indefinitely. Nothing times out.
- Reset mid-operation: the next cycle is IDLE and all outputs are at reset values. Words already written stay in the RAM; the loader does not undo them.

## Timing
- Reset values: `s_ready`=0, `ram_write_enable`=0, `ram_write_address`=0, `ram_input_data`=0, `busy`=0, `done`=0, `checksum`=0.
- `start` accepted at cycle S: `busy`=1 and (if `n`>0) `s_ready`=1 from S+1.
- Handshake at cycle T: at T+1, `ram_write_enable`=1 with `ram_write_address`=k and `ram_input_data` equal to that word. The write is committed at the end of T+1. Latency is one cycle.
- Last handshake at T: `s_ready`=0 from T+1 (WAIT), `done`=1 at T+2, `busy`=0 from T+3.
- `n`=0: `done`=1 at S+1, `busy`=0 at S+2, and `ram_write_enable` is never asserted.
- `ram_write_enable` is 0 in every cycle not directly following a handshake.
- `checksum` is updated in the same cycle as the corresponding `ram_write_enable` and is stable from WAIT until the next accepted `start`.

## Configuration
- `NORM_LOADER_CHECKSUM_EN` defined: `checksum` accumulates the XOR of every accepted word, as described above.
- Not defined: no checksum logic is built, and `checksum` is tied to 0 permanently. The port list is unchanged.

## Test plan
- `param_num`=4, words 0x11,0x22,0x33,0x44 with `s_valid` held high -> writes to addresses 0..3 on consecutive cycles. `done` is high 2 cycles after the 4th handshake. With the macro, `checksum`=0x44.
- `param_num`=3, `s_valid` toggling 1,0,0,1,0,1 -> exactly 3 writes at addresses 0,1,2 with the correct data. No write occurs in any gap cycle.
- `param_num`=0 -> `done` at S+1, `busy` low at S+2, no `ram_write_enable`, `s_ready` never high.
- `param_num`=2**ADDR_BITS+1 (1025 with defaults) -> clamped to 1024 writes at addresses 0..1023, then `done`. A 1025th word offered afterwards is not accepted.
- `start` pulsed during LOAD, followed by `rst` after 2 of 5 words -> the `start` is ignored. After reset all outputs are 0 and state is IDLE; addresses 0,1 hold the written data. A fresh `start` loads from address 0.
- Second `start` asserted in the cycle after `done` -> the new load begins from address 0 and `checksum` restarts from 0.
